// File: rtl/tcp_rto_pkg.sv
// Shared constants for the TCP RTO timer bank: Avalon register addresses
// and CMD register bit positions.
package tcp_rto_pkg;
    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd1;
    localparam logic [2:0] ADDR_LOAD     = 3'd2;
    localparam logic [2:0] ADDR_CMD      = 3'd3;
    localparam logic [2:0] ADDR_SEL      = 3'd4;
    localparam logic [2:0] ADDR_COUNT    = 3'd5;

    localparam int CMD_START_BIT = 8;
    localparam int CMD_STOP_BIT  = 9;
endpackage

// File: rtl/tcp_rto_timer_slot.sv
// One RTO countdown: stop beats start, start beats tick, and the counter
// halts at zero. expire_pulse is asserted in the cycle the expiry is decided.
module tcp_rto_timer_slot #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               tick,
    input  logic [COUNT_W-1:0] load_val,
    output logic [COUNT_W-1:0] count,
    output logic               running,
    output logic               expire_pulse
);
    logic do_start;
    logic do_tick;

    assign do_start     = start & ~stop;
    assign do_tick      = tick & running & ~start & ~stop;
    assign expire_pulse = (do_start && load_val == '0) ||
                          (do_tick && count == COUNT_W'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count   <= '0;
            running <= 1'b0;
        end else if (stop) begin
            running <= 1'b0;
        end else if (start) begin
            count   <= load_val;
            running <= (load_val != '0);
        end else if (do_tick) begin
            count <= count - COUNT_W'(1);
            if (count == COUNT_W'(1))
                running <= 1'b0;
        end
    end
endmodule

// File: rtl/tcp_rto_timer_bank.sv
// Bank of RTO countdown timers behind a 16-bit Avalon-MM slave, with a sticky
// W1C expiry status and a maskable interrupt.
module tcp_rto_timer_bank
    import tcp_rto_pkg::*;
#(
    parameter int NUM_TIMERS = 4,
    parameter int COUNT_W    = 16,
    parameter int IDX_W      = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        tick_i,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);
    logic                               tick_q;
    logic                               tick_rise;
    logic                               wr;
    logic                               cmd_wr;
    logic                               idx_ok;
    logic [IDX_W-1:0]                   cmd_idx;
    logic [NUM_TIMERS-1:0]              start_v;
    logic [NUM_TIMERS-1:0]              stop_v;
    logic [NUM_TIMERS-1:0]              running;
    logic [NUM_TIMERS-1:0]              expire_pulse;
    logic [NUM_TIMERS-1:0]              expired;
    logic [NUM_TIMERS-1:0]              irq_mask;
    logic [NUM_TIMERS-1:0][COUNT_W-1:0] counts;
    logic [COUNT_W-1:0]                 load_reg;
    logic [IDX_W-1:0]                   sel;
    logic [15:0]                        rd_nxt;
    logic                               unused_ok;

    assign unused_ok = ^writedata;
    assign tick_rise = tick_i & ~tick_q;
    assign wr        = chipselect & ~write_n;
    assign cmd_wr    = wr && address == ADDR_CMD;
    assign cmd_idx   = writedata[IDX_W-1:0];
    // Indices past the populated timers drop the whole command.
    assign idx_ok    = int'(cmd_idx) < NUM_TIMERS;

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_slot
        assign start_v[i] = cmd_wr & idx_ok & (int'(cmd_idx) == i) & writedata[CMD_START_BIT];
        assign stop_v[i]  = cmd_wr & idx_ok & (int'(cmd_idx) == i) & writedata[CMD_STOP_BIT];

        tcp_rto_timer_slot #(.COUNT_W(COUNT_W)) u_slot (
            .clk          (clk),
            .reset_n      (reset_n),
            .start        (start_v[i]),
            .stop         (stop_v[i]),
            .tick         (tick_rise),
            .load_val     (load_reg),
            .count        (counts[i]),
            .running      (running[i]),
            .expire_pulse (expire_pulse[i])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q   <= 1'b0;
            irq_mask <= '0;
            load_reg <= '0;
            sel      <= '0;
        end else begin
            tick_q <= tick_i;
            if (wr && address == ADDR_IRQ_MASK) irq_mask <= writedata[NUM_TIMERS-1:0];
            if (wr && address == ADDR_LOAD)     load_reg <= writedata[COUNT_W-1:0];
            if (wr && address == ADDR_SEL)      sel      <= writedata[IDX_W-1:0];
        end
    end

    // A fresh expiry outranks both a restart clear and a W1C in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            expired <= '0;
        end else begin
            for (int i = 0; i < NUM_TIMERS; i++) begin
                if (expire_pulse[i])
                    expired[i] <= 1'b1;
                else if ((start_v[i] & ~stop_v[i]) |
                         (wr && address == ADDR_STATUS && writedata[i]))
                    expired[i] <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_nxt = '0;
        case (address)
            ADDR_STATUS:   rd_nxt[NUM_TIMERS-1:0] = expired;
            ADDR_IRQ_MASK: rd_nxt[NUM_TIMERS-1:0] = irq_mask;
            ADDR_LOAD:     rd_nxt[COUNT_W-1:0]    = load_reg;
            ADDR_CMD:      rd_nxt[NUM_TIMERS-1:0] = running;
            ADDR_SEL:      rd_nxt[IDX_W-1:0]      = sel;
            ADDR_COUNT:    if (int'(sel) < NUM_TIMERS) rd_nxt[COUNT_W-1:0] = counts[sel];
            default:       rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_nxt;
    end

    assign irq = |(expired & irq_mask);
endmodule

// File: tb/tb_tcp_rto_timer_bank.sv
// Directed bench for tcp_rto_timer_bank; register reads are scored against
// expectations queued when each read is issued.
module tb_tcp_rto_timer_bank;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        tick_i = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = '0;
    logic [15:0] readdata;
    logic        irq;
    logic [15:0] readdata3;
    logic        irq3;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];
    string       tag_q[$];

    tcp_rto_timer_bank dut (
        .clk(clk), .reset_n(reset_n), .tick_i(tick_i), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .irq(irq)
    );

    // Three-timer build to exercise the out-of-range command index.
    tcp_rto_timer_bank #(.NUM_TIMERS(3), .COUNT_W(16), .IDX_W(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .tick_i(tick_i), .address(address),
        .chipselect(chipselect), .write_n(write_n), .writedata(writedata),
        .readdata(readdata3), .irq(irq3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string tag);
        logic [15:0] e;
        string       t;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check(t, readdata, e);
    endtask

    task automatic tick_pulse();
        tick_i = 1'b1;
        @(negedge clk);
        tick_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state of every address
        check("reset_irq", {15'd0, irq}, 16'd0);
        for (int a = 0; a < 8; a++) rd(3'(a), 16'h0000, $sformatf("reset_rd%0d", a));

        // Timer 1 runs 3 ticks to expiry
        wr(3'd2, 16'd3);
        wr(3'd3, 16'h0101);
        wr(3'd1, 16'h0002);
        wr(3'd4, 16'd1);
        tick_pulse(); rd(3'd5, 16'd2, "t1_cnt2");
        tick_pulse(); rd(3'd5, 16'd1, "t1_cnt1");
        check("t1_irq_pre", {15'd0, irq}, 16'd0);
        tick_pulse(); rd(3'd5, 16'd0, "t1_cnt0");
        check("t1_irq_set", {15'd0, irq}, 16'd1);
        rd(3'd0, 16'h0002, "t1_status");
        rd(3'd3, 16'h0000, "t1_running");
        wr(3'd0, 16'h0002);
        check("t1_irq_w1c", {15'd0, irq}, 16'd0);

        // Level-high tick gives exactly one decrement
        wr(3'd2, 16'd5);
        wr(3'd3, 16'h0100);
        wr(3'd4, 16'd0);
        tick_i = 1'b1;
        repeat (10) @(negedge clk);
        tick_i = 1'b0;
        @(negedge clk);
        rd(3'd5, 16'd4, "level_tick");

        // Start coincident with a tick loads the full value
        wr(3'd2, 16'd7);
        tick_i = 1'b1;
        wr(3'd3, 16'h0102);
        tick_i = 1'b0;
        @(negedge clk);
        rd(3'd5, 16'd3, "t0_ticked");
        wr(3'd4, 16'd2);
        rd(3'd5, 16'd7, "start_tick_cnt");
        rd(3'd3, 16'h0005, "t2_running");
        wr(3'd3, 16'h0302);
        rd(3'd3, 16'h0001, "start_stop_run");
        rd(3'd5, 16'd7, "stop_keeps_cnt");

        // Expiry beats a coincident W1C
        wr(3'd2, 16'd1);
        wr(3'd3, 16'h0103);
        tick_i = 1'b1;
        wr(3'd0, 16'h0008);
        tick_i = 1'b0;
        @(negedge clk);
        rd(3'd0, 16'h0008, "expire_vs_w1c");
        wr(3'd0, 16'h0008);
        rd(3'd0, 16'h0000, "w1c_clear");

        // Start with LOAD=0 expires at once
        wr(3'd2, 16'd0);
        wr(3'd3, 16'h0101);
        check("load0_irq", {15'd0, irq}, 16'd1);
        rd(3'd0, 16'h0002, "load0_status");
        rd(3'd3, 16'h0001, "load0_running");

        // Asynchronous reset mid-count
        wr(3'd2, 16'd100);
        wr(3'd3, 16'h0100);
        wr(3'd4, 16'd0);
        rd(3'd5, 16'd100, "pre_reset_cnt");
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_rd", readdata, 16'd0);
        check("async_rst_irq", {15'd0, irq}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(3'd5, 16'd0, "post_rst_cnt");
        rd(3'd3, 16'd0, "post_rst_run");
        rd(3'd0, 16'd0, "post_rst_status");
        rd(3'd2, 16'd0, "post_rst_load");

        // Out-of-range index is ignored by the 3-timer build
        wr(3'd2, 16'd5);
        wr(3'd3, 16'h0103);
        rd(3'd3, 16'h0008, "idx3_run_n4");
        check("idx3_run_n3", readdata3, 16'h0000);
        wr(3'd3, 16'h0101);
        rd(3'd3, 16'h000a, "idx1_run_n4");
        check("idx1_run_n3", readdata3, 16'h0002);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
